// File: rtl/seq_pkg.sv
// Shared types and constants for the serial frame transmitter.
package seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPreamble,
        StPayload,
        StParity
    } state_e;

    localparam int unsigned PREAMBLE_LEN = 4;
    localparam logic [PREAMBLE_LEN-1:0] PREAMBLE = 4'b1011;

    // History contents right after the preamble, and the pattern that forces a stuffed 0.
    localparam logic [2:0] HIST_RESET = 3'b011;
    localparam logic [2:0] STUFF_TRIG = 3'b101;

endpackage

// File: rtl/seq_frame_tx_if.sv
// Payload handshake and serial line bundle for seq_frame_tx.
interface seq_frame_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              tx_bit;
    logic              tx_active;
    logic              frame_done;

    modport master (
        output in_data, in_valid,
        input  in_ready, tx_bit, tx_active, frame_done
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, tx_bit, tx_active, frame_done
    );
endinterface

// File: rtl/seq_stuff_tracker.sv
// Three-bit history of emitted frame bits; requests a stuffed 0 when it reads 101.
module seq_stuff_tracker
    import seq_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic shift,
    input  logic shift_bit,
    output logic stuff_req
);

    logic [2:0] hist_q;

    // History register: preset at the end of the preamble, shifts every emitted payload bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hist_q <= '0;
        end else if (load) begin
            hist_q <= HIST_RESET;
        end else if (shift) begin
            hist_q <= {hist_q[1:0], shift_bit};
        end
    end

    assign stuff_req = (hist_q == STUFF_TRIG);

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: preamble 1011, MSB-first payload with zero-bit stuffing.
// Optional even-parity bit when SEQ_FRAME_TX_PARITY_EN is defined.
module seq_frame_tx
    import seq_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input logic           clk,
    input logic           reset,
    seq_frame_tx_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    state_e              state_q, state_d;
    logic [2:0]          pcnt_q, pcnt_d;
    logic [CNT_W-1:0]    dcnt_q, dcnt_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                bit_q, bit_d;
    logic                active_q, active_d;
    logic                done_q, done_d;
`ifdef SEQ_FRAME_TX_PARITY_EN
    logic                par_q, par_d;
    logic                sent_q, sent_d;
`endif

    logic hist_load, hist_shift, stuff_req, emit_data;

    seq_stuff_tracker u_tracker (
        .clk       (clk),
        .reset     (reset),
        .load      (hist_load),
        .shift     (hist_shift),
        .shift_bit (bit_d),
        .stuff_req (stuff_req)
    );

    // State, counters and the registered serial outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            pcnt_q   <= '0;
            dcnt_q   <= '0;
            shreg_q  <= '0;
            bit_q    <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
            par_q    <= 1'b0;
            sent_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            dcnt_q   <= dcnt_d;
            shreg_q  <= shreg_d;
            bit_q    <= bit_d;
            active_q <= active_d;
            done_q   <= done_d;
`ifdef SEQ_FRAME_TX_PARITY_EN
            par_q    <= par_d;
            sent_q   <= sent_d;
`endif
        end
    end

    // Next-state and next-bit: state_q names the phase of the bit currently on the line.
    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        dcnt_d     = dcnt_q;
        shreg_d    = shreg_q;
        bit_d      = 1'b0;
        active_d   = 1'b0;
        done_d     = 1'b0;
        hist_load  = 1'b0;
        hist_shift = 1'b0;
        emit_data  = 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
        par_d      = par_q;
        sent_d     = sent_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    state_d  = StPreamble;
                    bit_d    = PREAMBLE[PREAMBLE_LEN-1];
                    active_d = 1'b1;
                    pcnt_d   = 3'd1;
                    dcnt_d   = '0;
                    shreg_d  = bus.in_data;
`ifdef SEQ_FRAME_TX_PARITY_EN
                    par_d    = ^bus.in_data;
                    sent_d   = 1'b0;
`endif
                end
            end
            StPreamble: begin
                if (pcnt_q < 3'(PREAMBLE_LEN)) begin
                    bit_d     = PREAMBLE[2'd3 - pcnt_q[1:0]];
                    active_d  = 1'b1;
                    pcnt_d    = pcnt_q + 3'd1;
                    hist_load = (pcnt_q == 3'(PREAMBLE_LEN - 1));
                end else begin
                    state_d   = StPayload;
                    emit_data = 1'b1;
                end
            end
            StPayload: begin
                if (dcnt_q == CNT_W'(DATA_W)) begin
`ifdef SEQ_FRAME_TX_PARITY_EN
                    state_d  = StParity;
                    active_d = 1'b1;
                    if (stuff_req) begin
                        hist_shift = 1'b1;
                    end else begin
                        bit_d  = par_q;
                        done_d = 1'b1;
                        sent_d = 1'b1;
                    end
`else
                    state_d = StIdle;
`endif
                end else begin
                    emit_data = 1'b1;
                end
            end
`ifdef SEQ_FRAME_TX_PARITY_EN
            StParity: begin
                if (sent_q) begin
                    state_d = StIdle;
                end else begin
                    // A stuffed 0 went out first; history now ends in 10, so no second stuff.
                    bit_d    = par_q;
                    active_d = 1'b1;
                    done_d   = 1'b1;
                    sent_d   = 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        // One payload slot: either a stuffed 0 (no data consumed) or the next MSB.
        if (emit_data) begin
            active_d   = 1'b1;
            hist_shift = 1'b1;
            if (!stuff_req) begin
                bit_d   = shreg_q[DATA_W-1];
                shreg_d = shreg_q << 1;
                dcnt_d  = dcnt_q + 1'b1;
`ifndef SEQ_FRAME_TX_PARITY_EN
                done_d  = (dcnt_q == CNT_W'(DATA_W - 1));
`endif
            end
        end
    end

    assign bus.in_ready   = (state_q == StIdle);
    assign bus.tx_bit     = bit_q;
    assign bus.tx_active  = active_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Self-checking bench for seq_frame_tx (build with SEQ_FRAME_TX_PARITY_EN to test parity).
module tb_seq_frame_tx;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    seq_frame_tx_if #(.DATA_W(8)) bus ();

    seq_frame_tx #(.DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Observations from the most recent captured frame.
    logic [63:0] obs_vec;
    int          obs_len;
    int          obs_done_cnt;
    int          obs_done_pos;
    int          obs_ready_hi;

    // Reference: build the line bit-by-bit; a 0 is inserted whenever the last three bits read 101.
    function automatic void model(input logic [7:0] d, output logic [63:0] v, output int n);
        logic q[$];
        q = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 7; i >= 0; i--) begin
            if (q[q.size()-3] == 1'b1 && q[q.size()-2] == 1'b0 && q[q.size()-1] == 1'b1)
                q.push_back(1'b0);
            q.push_back(d[i]);
        end
`ifdef SEQ_FRAME_TX_PARITY_EN
        if (q[q.size()-3] == 1'b1 && q[q.size()-2] == 1'b0 && q[q.size()-1] == 1'b1)
            q.push_back(1'b0);
        q.push_back(^d);
`endif
        v = '0;
        foreach (q[k]) v = {v[62:0], q[k]};
        n = q.size();
    endfunction

    // Present a word for one accepting edge; returns at the negedge showing frame bit 1.
    task automatic start_word(input logic [7:0] d, input bit hold);
        @(negedge clk);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        @(negedge clk);
        if (!hold) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
        end
    endtask

    // Sample the line at negedges while tx_active; stops on the first idle sample (bounded).
    task automatic capture();
        obs_vec = '0; obs_len = 0; obs_done_cnt = 0; obs_done_pos = 0; obs_ready_hi = 0;
        for (int i = 0; i < 64; i++) begin
            if (bus.tx_active !== 1'b1) break;
            obs_vec = {obs_vec[62:0], bus.tx_bit};
            obs_len++;
            if (bus.frame_done === 1'b1) begin
                obs_done_cnt++;
                obs_done_pos = obs_len;
            end
            if (bus.in_ready !== 1'b0) obs_ready_hi++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({bus.in_ready, bus.tx_bit, bus.tx_active, bus.frame_done} !== 4'b1000)
            $display("FAIL reset_outputs: got %b want 1000",
                     {bus.in_ready, bus.tx_bit, bus.tx_active, bus.frame_done});
        else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({bus.in_ready, bus.tx_active} !== 2'b10)
            $display("FAIL reset_release_idle: got %b want 10", {bus.in_ready, bus.tx_active});
        else pass_cnt++;
    endtask

    // Directed frame against a hand-written line pattern.
    task automatic test_directed(input logic [7:0] d, input logic [63:0] ev, input int en);
        start_word(d, 1'b0);
        capture();
        total_cnt++;
        if (obs_len !== en) $display("FAIL dir_len_%h: got %0d want %0d", d, obs_len, en);
        else pass_cnt++;
        total_cnt++;
        if (obs_vec !== ev) $display("FAIL dir_bits_%h: got %b want %b", d, obs_vec, ev);
        else pass_cnt++;
        total_cnt++;
        if (obs_done_cnt !== 1 || obs_done_pos !== en)
            $display("FAIL dir_done_%h: got cnt %0d pos %0d want 1 at %0d",
                     d, obs_done_cnt, obs_done_pos, en);
        else pass_cnt++;
        total_cnt++;
        if (obs_ready_hi !== 0 || bus.in_ready !== 1'b1 || bus.tx_bit !== 1'b0)
            $display("FAIL dir_ready_%h: got ready_hi %0d ready_after %b bit %b want 0 1 0",
                     d, obs_ready_hi, bus.in_ready, bus.tx_bit);
        else pass_cnt++;
    endtask

    task automatic test_random(input int n);
        logic [63:0] ev;
        int          en;
        logic [7:0]  d;
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            model(d, ev, en);
            start_word(d, 1'b0);
            capture();
            total_cnt++;
            if (obs_len !== en || obs_vec !== ev)
                $display("FAIL rand_%h: got %0d bits %b want %0d bits %b", d, obs_len, obs_vec,
                         en, ev);
            else pass_cnt++;
            total_cnt++;
            if (obs_done_cnt !== 1 || obs_done_pos !== en || obs_ready_hi !== 0)
                $display("FAIL rand_ctrl_%h: got done %0d@%0d ready_hi %0d want 1@%0d 0", d,
                         obs_done_cnt, obs_done_pos, obs_ready_hi, en);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] ev;
        int          en;
        logic [7:0]  d;
        int          done_seen;
        done_seen = 0;
        start_word(8'h5A, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (bus.frame_done === 1'b1) done_seen++;
            @(negedge clk);
        end
        reset = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({bus.tx_bit, bus.tx_active, bus.in_ready, bus.frame_done} !== 4'b0010 ||
            done_seen !== 0)
            $display("FAIL reset_mid: got %b done_seen %0d want 0010 0",
                     {bus.tx_bit, bus.tx_active, bus.in_ready, bus.frame_done}, done_seen);
        else pass_cnt++;
        reset = 1'b1;
        d = 8'($urandom);
        model(d, ev, en);
        start_word(d, 1'b0);
        capture();
        total_cnt++;
        if (obs_len !== en || obs_vec !== ev || obs_done_pos !== en)
            $display("FAIL reset_mid_next: got %0d bits %b done@%0d want %0d bits %b", obs_len,
                     obs_vec, obs_done_pos, en, ev);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] ev0, ev1;
        int          en0, en1;
        model(8'h00, ev0, en0);
        model(8'h01, ev1, en1);
        start_word(8'h00, 1'b1);
        capture();
        total_cnt++;
        if (obs_len !== en0 || obs_vec !== ev0)
            $display("FAIL b2b_first: got %0d bits %b want %0d bits %b", obs_len, obs_vec, en0,
                     ev0);
        else pass_cnt++;
        total_cnt++;
        if ({bus.tx_active, bus.tx_bit, bus.in_ready} !== 3'b001)
            $display("FAIL b2b_gap: got %b want 001", {bus.tx_active, bus.tx_bit, bus.in_ready});
        else pass_cnt++;
        bus.in_data = 8'h01;
        @(negedge clk);
        bus.in_valid = 1'b0;
        capture();
        total_cnt++;
        if (obs_len !== en1 || obs_vec !== ev1)
            $display("FAIL b2b_second: got %0d bits %b want %0d bits %b", obs_len, obs_vec,
                     en1, ev1);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
`ifdef SEQ_FRAME_TX_PARITY_EN
        test_directed(8'h00, 64'b1011000000000, 13);
        test_directed(8'hA5, 64'b101110100010100, 15);
        test_directed(8'hFF, 64'b1011111111110, 13);
`else
        test_directed(8'h00, 64'b101100000000, 12);
        test_directed(8'hA5, 64'b1011101000101, 13);
        test_directed(8'hFF, 64'b101111111111, 12);
`endif
        test_random(25);
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
